// File: rtl/blft.sv
`default_nettype none
// blft: 256x256 9-bit 3x3 edge-replicating smoothing filter (1-2-1 weights) over an internal image memory.
// Define BLFT_RANGE_EN to enable the bilateral range kernel (neighbours more than 32 from the centre are replaced by the centre value).
module blft (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_addr,
    input  logic [8:0]  in_data,
    output logic        out_valid,
    output logic [15:0] out_addr,
    output logic [8:0]  out_data,
    output logic        finish
);
    localparam logic [1:0] S_LOAD   = 2'd0;
    localparam logic [1:0] S_FILTER = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] beat_q, beat_d;
    logic [15:0] pix_q, pix_d;
    logic [3:0]  tap_q, tap_d;
    logic [13:0] acc_q, acc_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] out_addr_q, out_addr_d;
    logic [8:0]  out_data_q, out_data_d;
    logic        finish_q, finish_d;

    logic [8:0]  mem [65536];
    logic [8:0]  rd_data_q;
    logic [15:0] rd_addr;
    logic [7:0]  row, col, row_m, row_p, col_m, col_p;
    logic [8:0]  q;
    logic [1:0]  sh;
    logic [13:0] term;

    assign row   = pix_q[15:8];
    assign col   = pix_q[7:0];
    assign row_m = (row == 8'd0)   ? row : row - 8'd1;
    assign row_p = (row == 8'd255) ? row : row + 8'd1;
    assign col_m = (col == 8'd0)   ? col : col - 8'd1;
    assign col_p = (col == 8'd255) ? col : col + 8'd1;

    // Centre is fetched first so the range kernel can compare every later tap against it.
    always_comb begin
        rd_addr = pix_q;
        case (tap_q)
            4'd1:    rd_addr = {row_m, col_m};
            4'd2:    rd_addr = {row_m, col};
            4'd3:    rd_addr = {row_m, col_p};
            4'd4:    rd_addr = {row,   col_m};
            4'd5:    rd_addr = {row,   col_p};
            4'd6:    rd_addr = {row_p, col_m};
            4'd7:    rd_addr = {row_p, col};
            4'd8:    rd_addr = {row_p, col_p};
            default: rd_addr = pix_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && state_q == S_LOAD && in_valid)
            mem[in_addr] <= in_data;
        rd_data_q <= mem[rd_addr];
    end

`ifdef BLFT_RANGE_EN
    logic [8:0] centre_q;
    logic [8:0] diff;

    always_ff @(posedge clk) begin
        if (rst)
            centre_q <= 9'd0;
        else if (state_q == S_FILTER && tap_q == 4'd1)
            centre_q <= rd_data_q;
    end

    always_comb begin
        diff = (rd_data_q >= centre_q) ? rd_data_q - centre_q : centre_q - rd_data_q;
        q    = (tap_q == 4'd1 || diff <= 9'd32) ? rd_data_q : centre_q;
    end
`else
    always_comb q = rd_data_q;
`endif

    // rd_data_q during tap_q=t holds tap t-1; weight is a shift of 2 (centre), 1 (edge) or 0 (corner).
    always_comb begin
        case (tap_q)
            4'd1:                      sh = 2'd2;
            4'd3, 4'd5, 4'd6, 4'd8:    sh = 2'd1;
            default:                   sh = 2'd0;
        endcase
        term = {5'd0, q} << sh;
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        pix_d       = pix_q;
        tap_d       = tap_q;
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        finish_d    = finish_q;
        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    beat_d = beat_q + 16'd1;
                    if (beat_q == 16'hFFFF) begin
                        state_d = S_FILTER;
                        pix_d   = 16'd0;
                        tap_d   = 4'd0;
                    end
                end
            end
            S_FILTER: begin
                if (tap_q == 4'd0) begin
                    tap_d = 4'd1;
                end else if (tap_q != 4'd9) begin
                    acc_d = (tap_q == 4'd1) ? term : acc_q + term;
                    tap_d = tap_q + 4'd1;
                end else begin
                    out_valid_d = 1'b1;
                    out_addr_d  = pix_q;
                    out_data_d  = 9'((acc_q + term + 14'd8) >> 4);
                    tap_d       = 4'd0;
                    pix_d       = pix_q + 16'd1;
                    if (pix_q == 16'hFFFF)
                        state_d = S_DONE;
                end
            end
            S_DONE:  finish_d = 1'b1;
            default: state_d  = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOAD;
            beat_q      <= 16'd0;
            pix_q       <= 16'd0;
            tap_q       <= 4'd0;
            acc_q       <= 14'd0;
            out_valid_q <= 1'b0;
            out_addr_q  <= 16'd0;
            out_data_q  <= 9'd0;
            finish_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            pix_q       <= pix_d;
            tap_q       <= tap_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            finish_q    <= finish_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign finish    = finish_q;
endmodule
`default_nettype wire

// File: tb/tb_blft.sv
`default_nettype none
// tb_blft: directed self-checking bench for blft (sparse image, early-row output checks, reset abort).
module tb_blft;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_addr = 16'd0;
    logic [8:0]  in_data = 9'd0;
    logic        out_valid;
    logic [15:0] out_addr;
    logic [8:0]  out_data;
    logic        finish;

    int checks   = 0;
    int failures = 0;
    logic [8:0] img [65536];

    localparam int N_CHECK = 1792;

`ifdef BLFT_RANGE_EN
    localparam int E_C00 = 160, E_C01 = 0,  E_C11 = 0;
    localparam int E_IC  = 500, E_IE  = 0,  E_ID  = 0, E_THR = 104;
`else
    localparam int E_C00 = 90,  E_C01 = 30, E_C11 = 10;
    localparam int E_IC  = 125, E_IE  = 63, E_ID  = 31, E_THR = 50;
`endif

    blft dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .finish    (finish)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: weight (2-|dr|)*(2-|dc|) over a clamped 3x3 window.
    function automatic int model(input int a);
        int r, c, rr, cc, p, w, ctr, sum;
        r   = a / 256;
        c   = a % 256;
        ctr = int'(img[a]);
        sum = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                rr = r + dr;
                cc = c + dc;
                if (rr < 0) rr = 0;
                if (rr > 255) rr = 255;
                if (cc < 0) cc = 0;
                if (cc > 255) cc = 255;
                p = int'(img[rr * 256 + cc]);
                w = (2 - (dr < 0 ? -dr : dr)) * (2 - (dc < 0 ? -dc : dc));
`ifdef BLFT_RANGE_EN
                if ((p > ctr ? p - ctr : ctr - p) > 32) p = ctr;
`endif
                sum += w * p;
            end
        end
        return (sum + 8) / 16;
    endfunction

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_addr  = 16'd0;
        in_data  = 9'd511;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_addr !== 16'd0) begin failures++; $display("FAIL reset_out_addr got=%h exp=0000", out_addr); end
        checks++; if (out_data !== 9'd0) begin failures++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
        checks++; if (finish !== 1'b0) begin failures++; $display("FAIL reset_finish got=%b exp=0", finish); end
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    // Address 0 goes last, so a beat miscounted during reset would leave pixel 0 unwritten.
    task automatic test_load();
        int seen = 0;
        for (int i = 0; i < 65536; i++) begin
            if (i < 256) begin
                while ($urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                    if (out_valid) seen++;
                end
            end
            in_valid = 1'b1;
            in_addr  = 16'(i + 1);
            in_data  = img[16'(i + 1)];
            @(negedge clk);
            if (out_valid) seen++;
        end
        // Writes outside LOAD must not touch pixel 0.
        in_valid = 1'b1;
        in_addr  = 16'd0;
        in_data  = 9'd0;
        checks++; if (seen != 0) begin failures++; $display("FAIL load_no_output got=%0d pulses exp=0", seen); end
    endtask

    task automatic test_filter();
        int waited;
        int hexp;
        for (int k = 0; k < N_CHECK; k++) begin
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (!out_valid && waited <= 16);
            checks++;
            if (!out_valid) begin
                failures++;
                $display("FAIL filter_timeout result=%0d waited=%0d cycles exp<=16", k, waited);
                break;
            end
            checks++; if (out_addr !== 16'(k)) begin failures++; $display("FAIL filter_addr got=%h exp=%h", out_addr, 16'(k)); end
            checks++; if (out_data !== 9'(model(k))) begin failures++; $display("FAIL filter_data addr=%h got=%0d exp=%0d", 16'(k), out_data, model(k)); end
            checks++; if (finish !== 1'b0) begin failures++; $display("FAIL filter_finish addr=%h got=%b exp=0", 16'(k), finish); end
            case (k)
                'h0000:                           hexp = E_C00;
                'h0001, 'h0100:                   hexp = E_C01;
                'h0101:                           hexp = E_C11;
                'h0264:                           hexp = 5;
                'h0164, 'h0265, 'h0263, 'h0364:   hexp = 3;
                'h0163, 'h0365:                   hexp = 1;
                'h0332:                           hexp = E_IC;
                'h0232, 'h0331, 'h0333, 'h0432:   hexp = E_IE;
                'h0231, 'h0433:                   hexp = E_ID;
                'h050A:                           hexp = E_THR;
                default:                          hexp = -1;
            endcase
            if (hexp >= 0) begin
                checks++;
                if (out_data !== 9'(hexp)) begin
                    failures++;
                    $display("FAIL hand_value addr=%h got=%0d exp=%0d", 16'(k), out_data, hexp);
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        int seen = 0;
        rst      = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL abort_out_valid got=%b exp=0", out_valid); end
        checks++; if (finish !== 1'b0) begin failures++; $display("FAIL abort_finish got=%b exp=0", finish); end
        checks++; if (out_addr !== 16'd0) begin failures++; $display("FAIL abort_out_addr got=%h exp=0000", out_addr); end
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            in_valid = 1'b1;
            in_addr  = 16'(i);
            in_data  = 9'(i);
            @(negedge clk);
            if (out_valid) seen++;
        end
        in_valid = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL abort_no_output got=%0d pulses exp=0", seen); end
        checks++; if (finish !== 1'b0) begin failures++; $display("FAIL abort_finish_late got=%b exp=0", finish); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) img[i] = 9'd0;
        img[16'h0000] = 9'd160;
        img[16'h0264] = 9'd20;
        img[16'h0332] = 9'd500;
        img[16'h0509] = 9'd67;
        img[16'h050A] = 9'd100;
        img[16'h050B] = 9'd132;

        @(negedge clk);
        test_reset();
        test_load();
        test_filter();
        test_reset_abort();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
